hazard_unit: RTL and testbench

- Pipeline hazard and stall controller for the five-stage RV32 core.
- Consumes the E/M/W control-register outputs (ResultSrcE, PCSrcE, RegWriteM, RegWriteW) and register specifiers.
- Produces forwarding selects, per-stage stall/flush, and FlushE for the control-register block.
- Also owns a data-memory wait FSM that freezes the pipe while an M-stage access is not ready, with timeout.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_unit_fwd_sel.sv | 19 +
 rtl/hazard_unit.sv | 177 +++++++++++++++++
 tb/tb_hazard_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the RV32 hazard/stall controller.
package hazard_pkg;
  localparam logic [2:0] RESULT_MEM = 3'b001;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding select for one E-stage source operand; M result wins over W.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       regwrite_m_i,
  input  logic       regwrite_w_i,
  output logic [1:0] sel_o
);
  always_comb begin
    sel_o = FWD_RF;
    if (rs_i != 5'd0 && regwrite_m_i && rs_i == rd_m_i)
      sel_o = FWD_M;
    else if (rs_i != 5'd0 && regwrite_w_i && rs_i == rd_w_i)
      sel_o = FWD_W;
  end
endmodule

// File: rtl/hazard_unit.sv
// Hazard/stall controller: forwarding, load-use stall, redirect flush and dmem wait FSM.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic [2:0] ResultSrcE,
  input  logic [1:0] PCSrcE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemAccessM,
  input  logic       dmem_ready,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       mem_timeout,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] load_use_count
`endif
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0][4:0] rs_e;
  logic [1:0][1:0] fwd;

  assign rs_e = {Rs2E, Rs1E};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel u_fwd (
        .rs_i        (rs_e[gi]),
        .rd_m_i      (RdM),
        .rd_w_i      (RdW),
        .regwrite_m_i(RegWriteM),
        .regwrite_w_i(RegWriteW),
        .sel_o       (fwd[gi])
      );
    end
  endgenerate

  assign ForwardAE = reset ? fwd[0] : FWD_RF;
  assign ForwardBE = reset ? fwd[1] : FWD_RF;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout_pulse;
  logic             lw_stall, force_rel, mem_stall;
  logic             unused_pcsrc;

  assign unused_pcsrc = PCSrcE[1];

  assign lw_stall  = (ResultSrcE == RESULT_MEM) && (RdE != 5'd0) &&
                     (Rs1D == RdE || Rs2D == RdE);
  assign force_rel = (state_q == WAIT) && (cnt_q == CNT_LAST);
  assign mem_stall = MemAccessM && !dmem_ready && !force_rel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Ready wins over a coincident forced release: that is a normal completion.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    timeout_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemAccessM && !dmem_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (force_rel) begin
          state_d       = IDLE;
          cnt_d         = '0;
          err_d         = 1'b1;
          timeout_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A memory stall freezes everything and defers any redirect/load-use bubble.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE[0];
        FlushE = lw_stall | PCSrcE[0];
      end
    end
  end

  assign mem_timeout = reset & timeout_pulse;
  assign mem_err     = reset & err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic [31:0] lu_q, lu_d;

  assign stall_d = stall_q + {31'd0, StallF};
  assign flush_d = flush_q + {31'd0, FlushD};
  assign lu_d    = lu_q + {31'd0, lw_stall & ~mem_stall};

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
      lu_q    <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      lu_q    <= lu_d;
    end
  end

  assign stall_cycles   = reset ? stall_q : 32'd0;
  assign flush_count    = reset ? flush_q : 32'd0;
  assign load_use_count = reset ? lu_q    : 32'd0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit, built with MEM_TIMEOUT=4.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [2:0] ResultSrcE;
  logic [1:0] PCSrcE;
  logic       RegWriteM, RegWriteW, MemAccessM, dmem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       mem_timeout, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count, load_use_count;
`endif

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_timeout(mem_timeout), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count),
    .load_use_count(load_use_count)
`endif
  );

  // Stall/flush bundle in a fixed order: {F,D,E,M stalls, FlushD, FlushE, FlushW}.
  wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 3'b000; PCSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0;
    MemAccessM = 0; dmem_ready = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    Rs1E = 5; RdM = 5; RegWriteM = 1; PCSrcE = 2'b01;
    MemAccessM = 1; dmem_ready = 0; ResultSrcE = RESULT_MEM; RdE = 7; Rs1D = 7;
    cyc(); cyc();
    #1;
    nvec++;
    if (ForwardAE !== 2'b00) begin nmis++; $display("FAIL reset_fwd got %b want 00", ForwardAE); end
    nvec++;
    if ({ctl, mem_timeout, mem_err} !== 9'b0) begin
      nmis++; $display("FAIL reset_ctl got %b want 000000000", {ctl, mem_timeout, mem_err});
    end
    idle();
    reset = 1'b1;
    cyc();
    #1;
    nvec++;
    if ({ctl, mem_timeout, mem_err} !== 9'b0) begin
      nmis++; $display("FAIL post_reset_idle got %b want 000000000", {ctl, mem_timeout, mem_err});
    end
  endtask

  task automatic test_forward();
    idle();
    Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #1;
    nvec++;
    if (ForwardAE !== 2'b10) begin nmis++; $display("FAIL fwd_m_prio got %b want 10", ForwardAE); end
    nvec++;
    if (ForwardBE !== 2'b10) begin nmis++; $display("FAIL fwd_b_m got %b want 10", ForwardBE); end
    RegWriteM = 0;
    #1;
    nvec++;
    if (ForwardAE !== 2'b01) begin nmis++; $display("FAIL fwd_w got %b want 01", ForwardAE); end
    Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1;
    #1;
    nvec++;
    if (ForwardAE !== 2'b00) begin nmis++; $display("FAIL fwd_x0 got %b want 00", ForwardAE); end
    Rs1E = 12; Rs2E = 9; RdM = 3; RdW = 9;
    #1;
    nvec++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      nmis++; $display("FAIL fwd_mixed got %b want 0001", {ForwardAE, ForwardBE});
    end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    cyc();
    ResultSrcE = RESULT_MEM; RdE = 7; Rs2D = 7;
    #1;
    nvec++;
    if (ctl !== 7'b1100010) begin nmis++; $display("FAIL lw_stall got %b want 1100010", ctl); end
    cyc();
    // E now holds the bubble inserted by FlushE.
    ResultSrcE = 3'b000; RdE = 0;
    #1;
    nvec++;
    if (ctl !== 7'b0000000) begin nmis++; $display("FAIL lw_one_cycle got %b want 0000000", ctl); end
    ResultSrcE = RESULT_MEM; RdE = 0; Rs1D = 0; Rs2D = 0;
    #1;
    nvec++;
    if (ctl !== 7'b0000000) begin nmis++; $display("FAIL lw_rd0 got %b want 0000000", ctl); end
    ResultSrcE = 3'b010; RdE = 7; Rs1D = 7;
    #1;
    nvec++;
    if (ctl !== 7'b0000000) begin nmis++; $display("FAIL lw_notload got %b want 0000000", ctl); end
    idle();
  endtask

  task automatic test_redirect();
    idle();
    cyc();
    PCSrcE = 2'b01;
    #1;
    nvec++;
    if (ctl !== 7'b0000110) begin nmis++; $display("FAIL redirect got %b want 0000110", ctl); end
    PCSrcE = 2'b10;
    #1;
    nvec++;
    if (ctl !== 7'b0000000) begin nmis++; $display("FAIL redirect_bit1 got %b want 0000000", ctl); end
    idle();
  endtask

  task automatic test_mem_wait();
    idle();
    cyc();
    MemAccessM = 1; dmem_ready = 0; PCSrcE = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      nvec++;
      if ({ctl, mem_timeout} !== 8'b11110010) begin
        nmis++; $display("FAIL mem_wait_c%0d got %b want 11110010", c, {ctl, mem_timeout});
      end
      cyc();
    end
    dmem_ready = 1;
    #1;
    nvec++;
    if ({ctl, mem_timeout} !== 8'b00001100) begin
      nmis++; $display("FAIL mem_release got %b want 00001100", {ctl, mem_timeout});
    end
    cyc();
    idle();
    #1;
    nvec++;
    if ({ctl, mem_timeout, mem_err} !== 9'b0) begin
      nmis++; $display("FAIL mem_after got %b want 000000000", {ctl, mem_timeout, mem_err});
    end
  endtask

  task automatic test_timeout();
    idle();
    cyc();
    MemAccessM = 1; dmem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      nvec++;
      if ({StallF, StallM, FlushW, mem_timeout} !== 4'b1110) begin
        nmis++; $display("FAIL to_wait_c%0d got %b want 1110", c, {StallF, StallM, FlushW, mem_timeout});
      end
      cyc();
    end
    #1;
    nvec++;
    if ({ctl, mem_timeout, mem_err} !== 9'b000000010) begin
      nmis++; $display("FAIL to_pulse got %b want 000000010", {ctl, mem_timeout, mem_err});
    end
    cyc();
    MemAccessM = 0;
    #1;
    nvec++;
    if ({mem_timeout, mem_err} !== 2'b01) begin
      nmis++; $display("FAIL to_sticky got %b want 01", {mem_timeout, mem_err});
    end
    cyc();
    #1;
    nvec++;
    if (mem_err !== 1'b1) begin nmis++; $display("FAIL to_sticky2 got %b want 1", mem_err); end
    pulse_reset();
    #1;
    nvec++;
    if (mem_err !== 1'b0) begin nmis++; $display("FAIL to_err_clear got %b want 0", mem_err); end
  endtask

  task automatic test_ready_at_limit();
    idle();
    cyc();
    MemAccessM = 1; dmem_ready = 0;
    cyc(); cyc(); cyc(); cyc();
    dmem_ready = 1;
    #1;
    nvec++;
    if ({StallF, mem_timeout} !== 2'b00) begin
      nmis++; $display("FAIL ready_limit got %b want 00", {StallF, mem_timeout});
    end
    cyc();
    idle();
    #1;
    nvec++;
    if (mem_err !== 1'b0) begin nmis++; $display("FAIL ready_limit_err got %b want 0", mem_err); end
  endtask

  task automatic test_reset_mid_wait();
    int hit;
    idle();
    cyc();
    MemAccessM = 1; dmem_ready = 0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    MemAccessM = 0;
    #1;
    nvec++;
    if ({StallF, mem_timeout, mem_err} !== 3'b000) begin
      nmis++; $display("FAIL rst_wait got %b want 000", {StallF, mem_timeout, mem_err});
    end
    cyc();
    MemAccessM = 1;
    hit = -1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (mem_timeout === 1'b1) begin hit = k; break; end
      cyc();
    end
    // A cleared counter means a full fresh count: IDLE cycle plus four WAIT cycles.
    nvec++;
    if (hit != 4) begin nmis++; $display("FAIL rst_wait_count got %0d want 4", hit); end
    idle();
    pulse_reset();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    idle();
    pulse_reset();
    ResultSrcE = RESULT_MEM; RdE = 7; Rs1D = 7;
    cyc();
    idle();
    cyc();
    ResultSrcE = RESULT_MEM; RdE = 9; Rs2D = 9;
    cyc();
    idle();
    // Load-use condition present during the wait is masked by the memory stall.
    MemAccessM = 1; ResultSrcE = RESULT_MEM; RdE = 3; Rs1D = 3;
    cyc(); cyc(); cyc();
    idle();
    MemAccessM = 1; dmem_ready = 1;
    cyc();
    idle();
    PCSrcE = 2'b01;
    cyc();
    idle();
    #1;
    nvec++;
    if (stall_cycles !== 32'd5) begin nmis++; $display("FAIL perf_stall got %0d want 5", stall_cycles); end
    nvec++;
    if (load_use_count !== 32'd2) begin nmis++; $display("FAIL perf_lu got %0d want 2", load_use_count); end
    nvec++;
    if (flush_count !== 32'd1) begin nmis++; $display("FAIL perf_flush got %0d want 1", flush_count); end
    MemAccessM = 1; dmem_ready = 0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    idle();
    #1;
    nvec++;
    if ({stall_cycles, flush_count, load_use_count} !== 96'd0 || StallF !== 1'b0) begin
      nmis++; $display("FAIL perf_reset got %0d/%0d/%0d stallF %b want 0/0/0 stallF 0",
                       stall_cycles, flush_count, load_use_count, StallF);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_wait();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
